lfsr_counter_bank: RTL and testbench

Bank of CHANNELS independent WIDTH-bit XNOR Fibonacci LFSR counters. Each counter steps forward (increment) or backward via the inverse LFSR (decrement), and can be loaded directly. It serves as the counter array of a counting Bloom filter: per-channel zero flags, overflow/underflow pulses, saturate or wrap mode, and a registered read port.

---
 rtl/lfsr_counter_bank.sv | 140 ++++++++++++++
 tb/tb_lfsr_counter_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_counter_bank.sv
// Bank of CHANNELS XNOR Fibonacci LFSR counters with load, forward and inverse step.
// Latency: state updates on the sampling edge; rd_data and OF/UF/load_err are registered (1 cycle).
// Backpressure: none; one operation per cycle on channel sel, always accepted.
module lfsr_counter_bank #(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
  parameter bit               SATURATE = 1'b1,
  parameter int               SELW     = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                rstb,
  input  logic                WE,
  input  logic                Increment,
  input  logic                Decrement,
  input  logic [SELW-1:0]     sel,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [SELW-1:0]     rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] zero,
  output logic                OF,
  output logic                UF,
  output logic                load_err
);

  // All-ones is the XNOR lockup state; the terminal state is the last one before wrapping to 0.
  localparam logic [WIDTH-1:0] LOCKUP = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TERM   = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] lfsr_fwd(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ~^(s & TAPS)};
  endfunction

  // Undo the shift: the bit that fell off the top is recovered from the feedback equation.
  function automatic logic [WIDTH-1:0] lfsr_inv(input logic [WIDTH-1:0] s);
    return {~s[0] ^ (^(s[WIDTH-1:1] & TAPS[WIDTH-2:0])), s[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] state_q [CHANNELS];
  logic [WIDTH-1:0] state_d [CHANNELS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             of_q, of_d;
  logic             uf_q, uf_d;
  logic             load_err_q, load_err_d;

  logic             sel_ok;
  logic             rd_ok;
  logic             wr;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;

  // Resolve the single operation on channel sel, then the read port sample.
  always_comb begin
    sel_ok     = 32'(sel) < CHANNELS;
    rd_ok      = 32'(rd_sel) < CHANNELS;
    cur        = sel_ok ? state_q[sel] : '0;
    nxt        = cur;
    wr         = 1'b0;
    of_d       = 1'b0;
    uf_d       = 1'b0;
    load_err_d = 1'b0;

    if (sel_ok) begin
      if (WE) begin
        wr = 1'b1;
        if (wdata == LOCKUP) begin
          nxt        = '0;
          load_err_d = 1'b1;
        end else begin
          nxt = wdata;
        end
      end else if (Increment && !Decrement) begin
        wr = 1'b1;
        if (cur == TERM) begin
          of_d = 1'b1;
          nxt  = SATURATE ? TERM : '0;
        end else begin
          nxt = lfsr_fwd(cur);
        end
      end else if (Decrement && !Increment) begin
        wr = 1'b1;
        if (cur == '0) begin
          uf_d = 1'b1;
          nxt  = SATURATE ? '0 : TERM;
        end else begin
          nxt = lfsr_inv(cur);
        end
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = (wr && (sel == SELW'(i))) ? nxt : state_q[i];
    end

    // Samples pre-update state, so a same-edge write to rd_sel shows up one cycle later.
    rd_data_d = rd_ok ? state_q[rd_sel] : '0;
  end

  // Per-channel zero flags straight from the state registers.
  always_comb begin
    zero = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      zero[i] = (state_q[i] == '0);
    end
  end

  // Counter state registers.
  always_ff @(posedge CLK or posedge rstb) begin
    if (rstb) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Read port and single-cycle event flags.
  always_ff @(posedge CLK or posedge rstb) begin
    if (rstb) begin
      rd_data_q  <= '0;
      of_q       <= 1'b0;
      uf_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      of_q       <= of_d;
      uf_q       <= uf_d;
      load_err_q <= load_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign OF       = of_q;
  assign UF       = uf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_lfsr_counter_bank.sv
// Directed bench for lfsr_counter_bank: saturating and wrapping instances share one stimulus.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Each comparison is an immediate assertion that counts failures.
module tb_lfsr_counter_bank;

  logic       CLK;
  logic       rstb;
  logic       WE;
  logic       Increment;
  logic       Decrement;
  logic [1:0] sel;
  logic [7:0] wdata;
  logic [1:0] rd_sel;

  logic [7:0] rd_a, rd_b;
  logic [3:0] zero_a, zero_b;
  logic       of_a, of_b, uf_a, uf_b, le_a, le_b;

  int n_assert = 0;
  int n_fail   = 0;

  lfsr_counter_bank #(.WIDTH(8), .CHANNELS(4), .TAPS(8'hB8), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .rstb(rstb), .WE(WE), .Increment(Increment), .Decrement(Decrement),
    .sel(sel), .wdata(wdata), .rd_sel(rd_sel), .rd_data(rd_a), .zero(zero_a),
    .OF(of_a), .UF(uf_a), .load_err(le_a)
  );

  lfsr_counter_bank #(.WIDTH(8), .CHANNELS(4), .TAPS(8'hB8), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .rstb(rstb), .WE(WE), .Increment(Increment), .Decrement(Decrement),
    .sel(sel), .wdata(wdata), .rd_sel(rd_sel), .rd_data(rd_b), .zero(zero_b),
    .OF(of_b), .UF(uf_b), .load_err(le_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let it be sampled, and return 1 time unit after the edge.
  task automatic cyc(input logic we_i, input logic inc_i, input logic dec_i,
                     input logic [1:0] sel_i, input logic [7:0] wd_i);
    WE        = we_i;
    Increment = inc_i;
    Decrement = dec_i;
    sel       = sel_i;
    wdata     = wd_i;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rstb = 1'b1; WE = 1'b0; Increment = 1'b0; Decrement = 1'b0;
    sel = 2'd0; wdata = 8'h00; rd_sel = 2'd1;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rd",   rd_a,   32'h00);
    chk("rst_zero", zero_a, 32'hF);
    chk("rst_flags", {of_a, uf_a, le_a}, 32'h0);
    chk("rst_zero_b", zero_b, 32'hF);
    rstb = 1'b0;

    // 1: forward steps on ch1: 00 -> 01 -> 03 -> 07 -> 0F -> 1E.
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t1_zero_first", zero_a, 32'hD);
    chk("t1_rd0", rd_a, 32'h00);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t1_rd1", rd_a, 32'h01);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t1_rd2", rd_a, 32'h03);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t1_rd3", rd_a, 32'h07);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t1_rd4", rd_a, 32'h0F);
    cyc(1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
    chk("t1_rd5", rd_a, 32'h1E);
    chk("t1_zero_others", zero_a, 32'hD);
    chk("t1_no_of", of_a, 32'h0);

    // 2: inverse steps back to 0, then underflow.
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_rd_old", rd_a, 32'h1E);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_rd_0f", rd_a, 32'h0F);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_rd_07", rd_a, 32'h07);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_rd_03", rd_a, 32'h03);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_rd_01", rd_a, 32'h01);
    chk("t2_zero1", zero_a[1], 32'h1);
    chk("t2_uf_early", uf_a, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_uf1", uf_a, 32'h1);
    chk("t2_rd_hold0", rd_a, 32'h00);
    chk("t2_uf_wrap", uf_b, 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    chk("t2_uf_b2b", uf_a, 32'h1);
    chk("t2_zero1_held", zero_a[1], 32'h1);
    chk("t2_uf_wrap_off", uf_b, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
    chk("t2_uf_clear", uf_a, 32'h0);
    chk("t2_rd_sat", rd_a, 32'h00);
    chk("t2_rd_wrap", rd_b, 32'hC0);

    // 3: load terminal state, then increment past it.
    rd_sel = 2'd2;
    cyc(1'b1, 1'b0, 1'b0, 2'd2, 8'h80);
    chk("t3_load_no_of", of_a, 32'h0);
    chk("t3_zero2_load", zero_a[2], 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    chk("t3_of_sat", of_a, 32'h1);
    chk("t3_of_wrap", of_b, 32'h1);
    chk("t3_zero2_sat", zero_a[2], 32'h0);
    chk("t3_zero2_wrap", zero_b[2], 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 2'd2, 8'h00);
    chk("t3_of_pulse", of_a, 32'h0);
    chk("t3_rd_sat", rd_a, 32'h80);
    chk("t3_rd_wrap", rd_b, 32'h00);

    // 4: illegal load, then load wins over increment.
    rd_sel = 2'd3;
    cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'hFF);
    chk("t4_load_err", le_a, 32'h1);
    chk("t4_load_err_b", le_b, 32'h1);
    chk("t4_no_ofuf", {of_a, uf_a}, 32'h0);
    chk("t4_zero3", zero_a[3], 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'h1E);
    chk("t4_le_pulse", le_a, 32'h0);
    chk("t4_rd_old", rd_a, 32'h00);
    cyc(1'b0, 1'b0, 1'b0, 2'd3, 8'h00);
    chk("t4_rd_loaded", rd_a, 32'h1E);

    // 5: simultaneous inc+dec holds; same-edge read shows old value.
    rd_sel = 2'd0;
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h07);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
    chk("t5_no_flags", {of_a, uf_a, le_a}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t5_hold", rd_a, 32'h07);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    chk("t5_rd_pre", rd_a, 32'h07);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("t5_rd_post", rd_a, 32'h0F);

    // 6: asynchronous reset in the middle of an increment burst.
    rd_sel = 2'd1;
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
    chk("t6_pre_of", of_a, 32'h1);
    chk("t6_pre_rd", rd_a, 32'h07);
    #3;
    rstb = 1'b1;
    #1;
    chk("t6_async_rd", rd_a, 32'h00);
    chk("t6_async_zero", zero_a, 32'hF);
    chk("t6_async_flags", {of_a, uf_a, le_a}, 32'h0);
    chk("t6_async_zero_b", zero_b, 32'hF);
    @(posedge CLK);
    #1;
    chk("t6_held_in_rst", zero_a, 32'hF);
    rstb = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
    chk("t6_first_inc_zero", zero_a, 32'hD);
    cyc(1'b0, 1'b0, 1'b0, 2'd1, 8'h00);
    chk("t6_first_inc_rd", rd_a, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
